// File: rtl/picosoc_gpio_ctrl.sv
// picosoc_gpio_ctrl: memory-mapped GPIO block for the PicoSoC iomem bus.
// It holds the OUT, DIR, IN, IRQ_EN, IRQ_EDGE and IRQ_STAT registers.
// The pin inputs pass through a synchroniser before anything else sees them.
// Edge detection is held off for a few cycles after reset release.
// The interrupt output is a registered level.
module picosoc_gpio_ctrl #(
    parameter int          WIDTH       = 16,
    parameter logic [7:0]  BASE_ADDR   = 8'h03,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [31:0]      iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam logic [2:0] ARM_CYCLES = 3'(SYNC_STAGES + 1);

    localparam logic [2:0] OFF_OUT   = 3'd0;
    localparam logic [2:0] OFF_DIR   = 3'd1;
    localparam logic [2:0] OFF_IN    = 3'd2;
    localparam logic [2:0] OFF_EN    = 3'd3;
    localparam logic [2:0] OFF_EDGE  = 3'd4;
    localparam logic [2:0] OFF_STAT  = 3'd5;

    logic             r_ready;
    logic [31:0]      r_rdata;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_irqEn;
    logic [WIDTH-1:0] r_irqEdge;
    logic [WIDTH-1:0] r_irqStat;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [2:0]       r_armCnt;
    logic             r_irq;

    logic             w_sel;
    logic             w_wr;
    logic [2:0]       w_offset;
    logic [31:0]      w_byteMask;
    logic [WIDTH-1:0] w_laneMask;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_syncOut;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_statClr;
    logic             w_armed;
    logic [31:0]      w_readMux;
    logic             w_unused;

    // Zero-extend a pin-wide value to the 32-bit bus width.
    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] t;
        t = '0;
        t[WIDTH-1:0] = v;
        return t;
    endfunction

    // Per-lane merge of write data into an existing register value.
    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] oldVal,
                                               input logic [WIDTH-1:0] newVal,
                                               input logic [WIDTH-1:0] mask);
        return (oldVal & ~mask) | (newVal & mask);
    endfunction

    // A new request is accepted only while no completion pulse is showing.
    // This makes back-to-back accesses complete on alternate cycles.
    assign w_sel      = iomem_valid && !r_ready && (iomem_addr[31:24] == BASE_ADDR);
    assign w_wr       = w_sel && (iomem_wstrb != 4'b0000);
    assign w_offset   = iomem_addr[4:2];
    assign w_byteMask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                         {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign w_laneMask = w_byteMask[WIDTH-1:0];
    assign w_wdata    = iomem_wdata[WIDTH-1:0];

    // Edges are taken only from the synchroniser output, never from the raw pins.
    assign w_syncOut  = r_sync[SYNC_STAGES-1];
    assign w_armed    = (r_armCnt == ARM_CYCLES);
    assign w_rise     = w_syncOut & ~r_prev;
    assign w_fall     = ~w_syncOut & r_prev;
    assign w_edge     = w_armed ? ((w_rise & r_irqEdge) | (w_fall & ~r_irqEdge)) : '0;
    assign w_statClr  = (w_wr && (w_offset == OFF_STAT)) ? (w_wdata & w_laneMask) : '0;

    assign w_unused   = ^{iomem_addr[23:5], iomem_addr[1:0], iomem_wdata, w_byteMask};

    // Read mux uses current register contents, so a write sees the pre-write value.
    always_comb begin
        w_readMux = '0;
        case (w_offset)
            OFF_OUT:  w_readMux = zext(r_out);
            OFF_DIR:  w_readMux = zext(r_dir);
            OFF_IN:   w_readMux = zext(w_syncOut);
            OFF_EN:   w_readMux = zext(r_irqEn);
            OFF_EDGE: w_readMux = zext(r_irqEdge);
            OFF_STAT: w_readMux = zext(r_irqStat);
            default:  w_readMux = '0;
        endcase
    end

    // Bus completion: one-cycle ready pulse with the registered read data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= w_sel;
            r_rdata <= w_sel ? w_readMux : '0;
        end
    end

    // Read/write configuration registers, updated per byte lane.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out     <= '0;
            r_dir     <= '0;
            r_irqEn   <= '0;
            r_irqEdge <= '0;
        end else if (w_wr) begin
            case (w_offset)
                OFF_OUT:  r_out     <= merge(r_out, w_wdata, w_laneMask);
                OFF_DIR:  r_dir     <= merge(r_dir, w_wdata, w_laneMask);
                OFF_EN:   r_irqEn   <= merge(r_irqEn, w_wdata, w_laneMask);
                OFF_EDGE: r_irqEdge <= merge(r_irqEdge, w_wdata, w_laneMask);
                default:  ;
            endcase
        end
    end

    // Input synchroniser chain plus the previous-value register for edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_syncOut;
        end
    end

    // Arm counter keeps edge detection off while the synchroniser fills after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_armCnt <= '0;
        end else if (r_armCnt != ARM_CYCLES) begin
            r_armCnt <= r_armCnt + 3'd1;
        end
    end

    // Interrupt status: write-one-to-clear.
    // A new edge in the same cycle as a clear wins, so the bit stays set.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_irqStat <= '0;
        end else begin
            r_irqStat <= (r_irqStat & ~w_statClr) | w_edge;
        end
    end

    // Registered interrupt level from the enabled status bits.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_irqStat & r_irqEn);
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign gpio_out    = r_out;
    assign gpio_oe     = r_dir;
    assign irq         = r_irq;

endmodule
